load_store_sequencer: RTL and testbench

//  Sequences one load/store at a time from the execution-stage address/data generator to the data-memory port.

---
 rtl/load_store_sequencer_pkg.sv | 44 ++++
 rtl/load_store_align.sv | 53 +++++
 rtl/load_store_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_sequencer_pkg.sv
// Shared types and constants for the load/store sequencer: FSM state
// encodings, access-order and load-mask codes, the latched request record
// and the fault classification used when a request is accepted.
package load_store_sequencer_pkg;

  typedef enum logic [2:0] {
    LDSQ_IDLE  = 3'd0,
    LDSQ_REQ   = 3'd1,
    LDSQ_WAIT  = 3'd2,
    LDSQ_ACK   = 3'd3,
    LDSQ_FAULT = 3'd4,
    LDSQ_DRAIN = 3'd5
  } ldsq_state_e;

  localparam logic [1:0] ORDER_BYTE = 2'd0;
  localparam logic [1:0] ORDER_HALF = 2'd1;
  localparam logic [1:0] ORDER_WORD = 2'd2;
  localparam logic [1:0] ORDER_RSVD = 2'd3;

  localparam logic [1:0] LOAD_MASK_8  = 2'd0;
  localparam logic [1:0] LOAD_MASK_16 = 2'd1;
  localparam logic [1:0] LOAD_MASK_32 = 2'd2;

  // Request fields still needed after the memory port has taken its copy.
  typedef struct packed {
    logic        rw;
    logic [1:0]  load_shift;
    logic [1:0]  load_mask;
    logic        spr_valid;
    logic [31:0] spr;
    logic [4:0]  dest;
  } ldsq_req_t;

  // Reserved order always faults; misalignment only when checking is enabled.
  function automatic logic ldsq_is_fault(input logic [1:0] order,
                                         input logic [1:0] addr_lo,
                                         input logic       align_check);
    logic misaligned;
    misaligned = ((order == ORDER_HALF) && addr_lo[0]) ||
                 ((order == ORDER_WORD) && (addr_lo != 2'b00));
    return (order == ORDER_RSVD) || (align_check && misaligned);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables and lane-replicated store data for
// an outgoing request, and shift/zero-extend of returning load data.
module load_store_align
  import load_store_sequencer_pkg::*;
(
  input  logic [1:0]  order,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data_in,
  input  logic [31:0] ld_raw,
  input  logic [1:0]  ld_shift,
  input  logic [1:0]  ld_mask,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Byte enables and store replication from access order and low address bits.
  always_comb begin
    byte_en = 4'b0000;
    st_data = 32'h0;
    case (order)
      ORDER_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        st_data = {4{st_data_in[7:0]}};
      end
      ORDER_HALF: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        st_data = {2{st_data_in[15:0]}};
      end
      ORDER_WORD: begin
        byte_en = 4'b1111;
        st_data = st_data_in;
      end
      default: begin
        byte_en = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Load data: shift the addressed byte down to lane 0, then zero-extend.
  always_comb begin
    ld_shifted = ld_raw >> {ld_shift, 3'b000};
    case (ld_mask)
      LOAD_MASK_8:  ld_data = {24'h0, ld_shifted[7:0]};
      LOAD_MASK_16: ld_data = {16'h0, ld_shifted[15:0]};
      default:      ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// One-at-a-time load/store sequencer between the execution stage and the
// data-memory port. Holds a request until memory takes it, waits for load
// data, and returns a single writeback beat with data, SPR update and fault.
//
// Handshakes: the execution stage hands over a request in any cycle where
// iEXE_VALID=1 and oEXE_BUSY=0 (ignored if iFLUSH=1). Memory takes the
// request in any cycle where oMEM_REQ=1 and iMEM_BUSY=0; oMEM_* stay stable
// until then. Load data is taken in the cycle iMEM_VALID=1 while waiting.
// oWB_VALID is a one-cycle beat with no back-pressure.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter bit P_ALIGN_CHECK = 1'b1
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iEXE_VALID,
  output logic        oEXE_BUSY,
  input  logic        iEXE_RW,
  input  logic [31:0] iEXE_ADDR,
  input  logic [31:0] iEXE_DATA,
  input  logic [1:0]  iEXE_ORDER,
  input  logic [1:0]  iEXE_LOAD_SHIFT,
  input  logic [1:0]  iEXE_LOAD_MASK,
  input  logic        iEXE_SPR_VALID,
  input  logic [31:0] iEXE_SPR,
  input  logic [4:0]  iEXE_DEST,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oWB_VALID,
  output logic [4:0]  oWB_DEST,
  output logic [31:0] oWB_DATA,
  output logic        oWB_SPR_VALID,
  output logic [31:0] oWB_SPR,
  output logic        oWB_FAULT,
  output ldsq_state_e oDBG_STATE
);

  ldsq_state_e state_q, state_d;
  ldsq_req_t   req_q, req_d;
  logic        mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        wb_valid_q, wb_valid_d, wb_spr_valid_q, wb_spr_valid_d;
  logic        wb_fault_q, wb_fault_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d, wb_spr_q, wb_spr_d;

  logic        accept, fault_in;
  logic [3:0]  al_byte_en;
  logic [31:0] al_st_data, al_ld_data;

  load_store_align u_align (
    .order      (iEXE_ORDER),
    .addr_lo    (iEXE_ADDR[1:0]),
    .st_data_in (iEXE_DATA),
    .ld_raw     (iMEM_DATA),
    .ld_shift   (req_q.load_shift),
    .ld_mask    (req_q.load_mask),
    .byte_en    (al_byte_en),
    .st_data    (al_st_data),
    .ld_data    (al_ld_data)
  );

  assign accept   = iEXE_VALID && (state_q == LDSQ_IDLE) && !iFLUSH;
  assign fault_in = ldsq_is_fault(iEXE_ORDER, iEXE_ADDR[1:0], P_ALIGN_CHECK);

  // Next-state, memory-port and writeback-beat computation.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    mem_req_d      = mem_req_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_mask_d     = mem_mask_q;
    mem_data_d     = mem_data_q;
    wb_valid_d     = 1'b0;
    wb_spr_valid_d = 1'b0;
    wb_fault_d     = 1'b0;
    wb_dest_d      = 5'h0;
    wb_data_d      = 32'h0;
    wb_spr_d       = 32'h0;
    case (state_q)
      LDSQ_IDLE: begin
        if (accept) begin
          req_d = '{rw: iEXE_RW, load_shift: iEXE_LOAD_SHIFT, load_mask: iEXE_LOAD_MASK,
                    spr_valid: iEXE_SPR_VALID, spr: iEXE_SPR, dest: iEXE_DEST};
          if (fault_in) begin
            state_d    = LDSQ_FAULT;
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b1;
            wb_dest_d  = iEXE_DEST;
            wb_spr_d   = iEXE_SPR;
          end else begin
            state_d    = LDSQ_REQ;
            mem_req_d  = 1'b1;
            mem_rw_d   = iEXE_RW;
            mem_addr_d = {iEXE_ADDR[31:2], 2'b00};
            mem_mask_d = al_byte_en;
            mem_data_d = al_st_data;
          end
        end
      end
      LDSQ_REQ: begin
        if (!iMEM_BUSY || iFLUSH) begin
          mem_req_d  = 1'b0;
          mem_rw_d   = 1'b0;
          mem_addr_d = 32'h0;
          mem_mask_d = 4'h0;
          mem_data_d = 32'h0;
        end
        if (iFLUSH) begin
          // A load memory already took still owes a data beat; absorb it.
          if (!iMEM_BUSY && !req_q.rw) state_d = LDSQ_DRAIN;
          else                         state_d = LDSQ_IDLE;
        end else if (!iMEM_BUSY) begin
          if (req_q.rw) begin
            state_d        = LDSQ_ACK;
            wb_valid_d     = 1'b1;
            wb_dest_d      = req_q.dest;
            wb_spr_valid_d = req_q.spr_valid;
            wb_spr_d       = req_q.spr;
          end else begin
            state_d = LDSQ_WAIT;
          end
        end
      end
      LDSQ_WAIT: begin
        if (iMEM_VALID) begin
          if (iFLUSH) begin
            state_d = LDSQ_IDLE;
          end else begin
            state_d        = LDSQ_ACK;
            wb_valid_d     = 1'b1;
            wb_dest_d      = req_q.dest;
            wb_data_d      = al_ld_data;
            wb_spr_valid_d = req_q.spr_valid;
            wb_spr_d       = req_q.spr;
          end
        end else if (iFLUSH) begin
          state_d = LDSQ_DRAIN;
        end
      end
      LDSQ_ACK, LDSQ_FAULT: state_d = LDSQ_IDLE;
      LDSQ_DRAIN: if (iMEM_VALID) state_d = LDSQ_IDLE;
      default: state_d = LDSQ_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q        <= LDSQ_IDLE;
      req_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_mask_q     <= 4'h0;
      mem_data_q     <= 32'h0;
      wb_valid_q     <= 1'b0;
      wb_spr_valid_q <= 1'b0;
      wb_fault_q     <= 1'b0;
      wb_dest_q      <= 5'h0;
      wb_data_q      <= 32'h0;
      wb_spr_q       <= 32'h0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      mem_req_q      <= mem_req_d;
      mem_rw_q       <= mem_rw_d;
      mem_addr_q     <= mem_addr_d;
      mem_mask_q     <= mem_mask_d;
      mem_data_q     <= mem_data_d;
      wb_valid_q     <= wb_valid_d;
      wb_spr_valid_q <= wb_spr_valid_d;
      wb_fault_q     <= wb_fault_d;
      wb_dest_q      <= wb_dest_d;
      wb_data_q      <= wb_data_d;
      wb_spr_q       <= wb_spr_d;
    end
  end

  assign oEXE_BUSY     = (state_q != LDSQ_IDLE);
  assign oMEM_REQ      = mem_req_q;
  assign oMEM_RW       = mem_rw_q;
  assign oMEM_ADDR     = mem_addr_q;
  assign oMEM_MASK     = mem_mask_q;
  assign oMEM_DATA     = mem_data_q;
  // A flush landing on the beat cycle kills the already-registered beat.
  assign oWB_VALID     = wb_valid_q && !iFLUSH;
  assign oWB_SPR_VALID = wb_spr_valid_q && !iFLUSH;
  assign oWB_FAULT     = wb_fault_q;
  assign oWB_DEST      = wb_dest_q;
  assign oWB_DATA      = wb_data_q;
  assign oWB_SPR       = wb_spr_q;
  assign oDBG_STATE    = state_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: directed scenarios plus random back-to-back
// accesses; writeback beats are checked against an expected queue.
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

  localparam int BW = 71; // {fault, spr_valid, spr[31:0], dest[4:0], data[31:0]}

  logic        iCLOCK, inRESET, iFLUSH, iEXE_VALID, oEXE_BUSY, iEXE_RW;
  logic [31:0] iEXE_ADDR, iEXE_DATA, iEXE_SPR;
  logic [1:0]  iEXE_ORDER, iEXE_LOAD_SHIFT, iEXE_LOAD_MASK;
  logic        iEXE_SPR_VALID;
  logic [4:0]  iEXE_DEST;
  logic        oMEM_REQ, iMEM_BUSY, oMEM_RW, iMEM_VALID;
  logic [31:0] oMEM_ADDR, oMEM_DATA, iMEM_DATA;
  logic [3:0]  oMEM_MASK;
  logic        oWB_VALID, oWB_SPR_VALID, oWB_FAULT;
  logic [4:0]  oWB_DEST;
  logic [31:0] oWB_DATA, oWB_SPR;
  ldsq_state_e oDBG_STATE;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  load_store_sequencer #(.P_ALIGN_CHECK(1'b1)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLUSH(iFLUSH),
    .iEXE_VALID(iEXE_VALID), .oEXE_BUSY(oEXE_BUSY), .iEXE_RW(iEXE_RW),
    .iEXE_ADDR(iEXE_ADDR), .iEXE_DATA(iEXE_DATA), .iEXE_ORDER(iEXE_ORDER),
    .iEXE_LOAD_SHIFT(iEXE_LOAD_SHIFT), .iEXE_LOAD_MASK(iEXE_LOAD_MASK),
    .iEXE_SPR_VALID(iEXE_SPR_VALID), .iEXE_SPR(iEXE_SPR), .iEXE_DEST(iEXE_DEST),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_RW(oMEM_RW),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_MASK(oMEM_MASK), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
    .oWB_VALID(oWB_VALID), .oWB_DEST(oWB_DEST), .oWB_DATA(oWB_DATA),
    .oWB_SPR_VALID(oWB_SPR_VALID), .oWB_SPR(oWB_SPR), .oWB_FAULT(oWB_FAULT),
    .oDBG_STATE(oDBG_STATE)
  );

  // Clock and watchdog
  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every beat must match the head of the expected queue,
  // and the SPR enable must never show outside a beat.
  always @(negedge iCLOCK) begin
    logic [BW-1:0] got, exp;
    if (inRESET === 1'b1) begin
      if (oWB_VALID === 1'b1) begin
        got = {oWB_FAULT, oWB_SPR_VALID, oWB_SPR, oWB_DEST, oWB_DATA};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got %h want no beat", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL wb_beat got %h want %h", got, exp);
          end
        end
      end else if (oWB_SPR_VALID !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL spr_outside_beat got %b want 0", oWB_SPR_VALID);
      end
    end
  end

  // Reference model
  function automatic logic [3:0] model_mask(input logic [1:0] order, input logic [1:0] a);
    case ({order, a})
      4'b00_00: return 4'b0001;
      4'b00_01: return 4'b0010;
      4'b00_10: return 4'b0100;
      4'b00_11: return 4'b1000;
      4'b01_00, 4'b01_01: return 4'b0011;
      4'b01_10, 4'b01_11: return 4'b1100;
      4'b10_00, 4'b10_01, 4'b10_10, 4'b10_11: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] model_st(input logic [1:0] order, input logic [31:0] d);
    if (order == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (order == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] r, input logic [1:0] sh,
                                           input logic [1:0] m);
    logic [31:0] t;
    t = r >> (8 * sh);
    if (m == 2'd0) return t & 32'h0000_00FF;
    if (m == 2'd1) return t & 32'h0000_FFFF;
    return t;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr, data,
                       input logic [1:0] order, shift, lmask,
                       input logic spv, input logic [31:0] spr, input logic [4:0] dest);
    iEXE_RW = rw; iEXE_ADDR = addr; iEXE_DATA = data; iEXE_ORDER = order;
    iEXE_LOAD_SHIFT = shift; iEXE_LOAD_MASK = lmask;
    iEXE_SPR_VALID = spv; iEXE_SPR = spr; iEXE_DEST = dest;
    iEXE_VALID = 1'b1;
    checks++;
    if (oEXE_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL issue_busy got %b want 0", oEXE_BUSY);
    end
    tick();
    iEXE_VALID = 1'b0;
  endtask

  // Full access: request hold/stability, data phase and beat timing.
  task automatic run_access(input string name, input logic rw, input logic [31:0] addr, data,
                            input logic [1:0] order, shift, lmask,
                            input logic spv, input logic [31:0] spr, input logic [4:0] dest,
                            input int busy_n, input int vdelay, input logic [31:0] rdata,
                            input logic [3:0] exp_mask, input logic [31:0] exp_mdata,
                            input logic [31:0] exp_wdata);
    int held;
    bit unstable;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    exp_q.push_back({1'b0, spv, spr, dest, exp_wdata});
    issue(rw, addr, data, order, shift, lmask, spv, spr, dest);
    checks++;
    if ({oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA} !== {1'b1, rw, exp_addr, exp_mask, exp_mdata}) begin
      errors++;
      $display("FAIL %s mem_port got req=%b rw=%b addr=%h mask=%b data=%h want req=1 rw=%b addr=%h mask=%b data=%h",
               name, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA, rw, exp_addr, exp_mask, exp_mdata);
    end
    held = 0;
    unstable = 0;
    iMEM_BUSY = (busy_n > 0);
    while (oMEM_REQ === 1'b1 && held < 32) begin
      if ({oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA} !== {rw, exp_addr, exp_mask, exp_mdata}) unstable = 1;
      held++;
      tick();
      iMEM_BUSY = (held < busy_n);
    end
    iMEM_BUSY = 1'b0;
    checks++;
    if (held != busy_n + 1) begin
      errors++;
      $display("FAIL %s req_cycles got %0d want %0d", name, held, busy_n + 1);
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL %s req_stable got changed want stable", name);
    end
    if (!rw) begin
      for (int d = 0; d < vdelay; d++) begin
        checks++;
        if (oWB_VALID !== 1'b0) begin
          errors++;
          $display("FAIL %s early_wb got %b want 0", name, oWB_VALID);
        end
        tick();
      end
      iMEM_VALID = 1'b1;
      iMEM_DATA = rdata;
      tick();
      iMEM_VALID = 1'b0;
      iMEM_DATA = $urandom;
    end
    checks++;
    if (oWB_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s wb_valid got %b want 1", name, oWB_VALID);
    end
    tick();
    checks++;
    if ({oWB_VALID, oEXE_BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_beat got valid=%b busy=%b want 0 0", name, oWB_VALID, oEXE_BUSY);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    inRESET = 1'b0;
    repeat (3) tick();
    checks++;
    if ({oEXE_BUSY, oMEM_REQ, oWB_VALID, oWB_FAULT, oWB_SPR_VALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {oEXE_BUSY, oMEM_REQ, oWB_VALID, oWB_FAULT, oWB_SPR_VALID});
    end
    checks++;
    if ({oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA, oWB_DEST, oWB_DATA, oWB_SPR} !== '0) begin
      errors++;
      $display("FAIL reset_fields got addr=%h mask=%b wbdata=%h want 0", oMEM_ADDR, oMEM_MASK, oWB_DATA);
    end
    checks++;
    if (oDBG_STATE !== LDSQ_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d", oDBG_STATE, LDSQ_IDLE);
    end
    inRESET = 1'b1;
    tick();
  endtask

  task automatic test_ld8();
    run_access("ld8", 1'b0, 32'h0000_1003, 32'h0, ORDER_BYTE, 2'd3, LOAD_MASK_8,
               1'b0, 32'h0, 5'd3, 2, 1, 32'hAABB_CCDD, 4'b1000, 32'h0, 32'h0000_00AA);
  endtask

  task automatic test_st16();
    run_access("st16", 1'b1, 32'h0000_2002, 32'h0000_1234, ORDER_HALF, 2'd0, LOAD_MASK_32,
               1'b0, 32'h0, 5'd7, 0, 0, 32'h0, 4'b1100, 32'h1234_1234, 32'h0);
  endtask

  task automatic test_spr_push();
    run_access("push32", 1'b1, 32'h0000_1FFC, 32'hDEAD_BEEF, ORDER_WORD, 2'd0, LOAD_MASK_32,
               1'b1, 32'h0000_0FFC, 5'd0, 1, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
  endtask

  task automatic test_fault();
    logic [31:0] addrs[3];
    logic [1:0]  orders[3];
    addrs  = '{32'h0000_3001, 32'h0000_4000, 32'h0000_4005};
    orders = '{ORDER_WORD, ORDER_RSVD, ORDER_HALF};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 1'b0, 32'h0, 5'd9, 32'h0});
      issue(1'b0, addrs[i], 32'h0, orders[i], 2'd0, LOAD_MASK_32, 1'b1, 32'h0, 5'd9);
      checks++;
      if ({oMEM_REQ, oWB_VALID, oWB_FAULT, oWB_SPR_VALID} !== 4'b0110) begin
        errors++;
        $display("FAIL fault%0d_beat got req/valid/fault/spr=%b want 0110", i,
                 {oMEM_REQ, oWB_VALID, oWB_FAULT, oWB_SPR_VALID});
      end
      tick();
      checks++;
      if ({oDBG_STATE, oEXE_BUSY, oMEM_REQ} !== {LDSQ_IDLE, 2'b00}) begin
        errors++;
        $display("FAIL fault%0d_idle got state=%0d busy=%b req=%b want 0 0 0", i,
                 oDBG_STATE, oEXE_BUSY, oMEM_REQ);
      end
    end
  endtask

  task automatic test_flush_wait();
    issue(1'b0, 32'h0000_5000, 32'h0, ORDER_WORD, 2'd0, LOAD_MASK_32, 1'b1, 32'h55, 5'd4);
    iMEM_BUSY = 1'b0;
    tick();
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        iMEM_VALID = 1'b1;
        iMEM_DATA = 32'h1111_2222;
      end
      checks++;
      if ({oEXE_BUSY, oWB_VALID} !== 2'b10) begin
        errors++;
        $display("FAIL flush_wait_c%0d got busy=%b valid=%b want 1 0", c, oEXE_BUSY, oWB_VALID);
      end
      tick();
    end
    iMEM_VALID = 1'b0;
    checks++;
    if ({oEXE_BUSY, oWB_VALID} !== 2'b00) begin
      errors++;
      $display("FAIL flush_wait_end got busy=%b valid=%b want 0 0", oEXE_BUSY, oWB_VALID);
    end
  endtask

  task automatic test_flush_misc();
    // Flush while memory is still busy: request dropped.
    issue(1'b0, 32'h0000_6000, 32'h0, ORDER_BYTE, 2'd0, LOAD_MASK_8, 1'b0, 32'h0, 5'd1);
    iMEM_BUSY = 1'b1;
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    iMEM_BUSY = 1'b0;
    checks++;
    if ({oDBG_STATE, oMEM_REQ} !== {LDSQ_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL flush_req got state=%0d req=%b want 0 0", oDBG_STATE, oMEM_REQ);
    end
    // Flush in the cycle memory takes a load: absorb the data beat.
    issue(1'b0, 32'h0000_6004, 32'h0, ORDER_WORD, 2'd0, LOAD_MASK_32, 1'b0, 32'h0, 5'd2);
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    checks++;
    if ({oDBG_STATE, oEXE_BUSY, oMEM_REQ} !== {LDSQ_DRAIN, 2'b10}) begin
      errors++;
      $display("FAIL flush_drain got state=%0d busy=%b req=%b want %0d 1 0",
               oDBG_STATE, oEXE_BUSY, oMEM_REQ, LDSQ_DRAIN);
    end
    iMEM_VALID = 1'b1;
    tick();
    iMEM_VALID = 1'b0;
    checks++;
    if (oEXE_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got busy=%b want 0", oEXE_BUSY);
    end
    // Flush on the beat cycle: no writeback.
    issue(1'b1, 32'h0000_6008, 32'h77, ORDER_WORD, 2'd0, LOAD_MASK_32, 1'b1, 32'h9, 5'd5);
    tick();
    iFLUSH = 1'b1;
    #1;
    checks++;
    if ({oWB_VALID, oWB_SPR_VALID} !== 2'b00) begin
      errors++;
      $display("FAIL flush_ack got valid=%b spr=%b want 0 0", oWB_VALID, oWB_SPR_VALID);
    end
    tick();
    iFLUSH = 1'b0;
    // Request presented together with flush in IDLE is ignored.
    iEXE_VALID = 1'b1;
    iFLUSH = 1'b1;
    tick();
    iEXE_VALID = 1'b0;
    iFLUSH = 1'b0;
    checks++;
    if ({oDBG_STATE, oMEM_REQ, oWB_VALID} !== {LDSQ_IDLE, 2'b00}) begin
      errors++;
      $display("FAIL flush_idle got state=%0d req=%b valid=%b want 0 0 0", oDBG_STATE, oMEM_REQ, oWB_VALID);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0000_7001, 32'h0, ORDER_BYTE, 2'd1, LOAD_MASK_8, 1'b0, 32'h0, 5'd6);
    iMEM_BUSY = 1'b1;
    tick();
    inRESET = 1'b0;
    tick();
    checks++;
    if ({oMEM_REQ, oEXE_BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid got req=%b busy=%b want 0 0", oMEM_REQ, oEXE_BUSY);
    end
    inRESET = 1'b1;
    iMEM_BUSY = 1'b0;
    tick();
    run_access("ld8_after_rst", 1'b0, 32'h0000_7001, 32'h0, ORDER_BYTE, 2'd1, LOAD_MASK_8,
               1'b0, 32'h0, 5'd6, 0, 0, 32'h1122_3344, 4'b0010, 32'h0, 32'h0000_0033);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  order, lmask;
      logic [31:0] addr, data, rdata, spr;
      logic        rw, spv;
      order = 2'($urandom_range(0, 2));
      addr  = $urandom;
      if (order == ORDER_HALF) addr[0] = 1'b0;
      if (order == ORDER_WORD) addr[1:0] = 2'b00;
      lmask = order;
      rw = 1'($urandom_range(0, 1));
      spv = 1'($urandom_range(0, 1));
      data = $urandom;
      rdata = $urandom;
      spr = $urandom;
      run_access("rand", rw, addr, data, order, addr[1:0], lmask, spv, spr,
                 5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), rdata,
                 model_mask(order, addr[1:0]), model_st(order, data),
                 rw ? 32'h0 : model_ld(rdata, addr[1:0], lmask));
    end
  endtask

  initial begin
    inRESET = 1'b0; iFLUSH = 1'b0; iEXE_VALID = 1'b0; iEXE_RW = 1'b0;
    iEXE_ADDR = '0; iEXE_DATA = '0; iEXE_ORDER = '0; iEXE_LOAD_SHIFT = '0;
    iEXE_LOAD_MASK = '0; iEXE_SPR_VALID = 1'b0; iEXE_SPR = '0; iEXE_DEST = '0;
    iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = '0;
    test_reset();
    test_ld8();
    test_st16();
    test_spr_push();
    test_fault();
    test_flush_wait();
    test_flush_misc();
    test_reset_mid();
    test_back_to_back();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
